// File: rtl/fir_isa_pkg.sv
// FIR sequencer ISA: opcodes and instruction field positions.
// Shared by the decoder, the pointer generator and the bench.
package fir_isa_pkg;

  localparam int OP_W    = 4;
  localparam int LOOP_W  = 12;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 28;
  localparam int ITER_HI = 27;
  localparam int ITER_LO = 16;
  localparam int SIZE_HI = 11;
  localparam int SIZE_LO = 0;

  localparam logic [OP_W-1:0] OP_NOP    = 4'h0;
  localparam logic [OP_W-1:0] OP_LOOP   = 4'h1;
  localparam logic [OP_W-1:0] OP_CLRACC = 4'h2;
  localparam logic [OP_W-1:0] OP_MAC    = 4'h3;
  localparam logic [OP_W-1:0] OP_LDSAMP = 4'h4;
  localparam logic [OP_W-1:0] OP_OUT    = 4'h5;
  localparam logic [OP_W-1:0] OP_HALT   = 4'hF;

  function automatic logic [OP_W-1:0] op_of(input logic [31:0] w);
    return w[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/fir_ptr_gen.sv
// Circular-buffer pointers for the FIR: sample write, coef and
// sample read pointers, all wrapping modulo TAPS (power of two).
module fir_ptr_gen #(
  parameter int TAPS  = 16,
  parameter int PTR_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             clr,
  input  logic             mac,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] cptr,
  output logic [PTR_W-1:0] sptr
);

  localparam logic [PTR_W-1:0] ONE = PTR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      cptr <= '0;
      sptr <= '0;
    end else if (ld) begin
      wptr <= wptr + ONE;
      sptr <= wptr;
      cptr <= '0;
    end else if (clr) begin
      cptr <= '0;
      sptr <= wptr - ONE;
    end else if (mac) begin
      cptr <= cptr + ONE;
      sptr <= sptr - ONE;
    end
  end

endmodule

// File: rtl/fir_instr_decode.sv
// FIR instruction decoder / address generator (consumer of sequencer).
// Build option DECODE_TRAP_EN: illegal instructions halt the core.
module fir_instr_decode
  import fir_isa_pkg::*;
#(
  parameter int TAPS   = 16,
  parameter int ADDR_W = 16,
  localparam int PTR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              loop_we,
  output logic [LOOP_W-1:0] loop_iter,
  output logic [LOOP_W-1:0] loop_size,
  output logic              samp_we,
  output logic [PTR_W-1:0]  samp_waddr,
  output logic [PTR_W-1:0]  samp_raddr,
  output logic [PTR_W-1:0]  coef_addr,
  output logic              acc_clr,
  output logic              mac_en,
  output logic              out_we,
  output logic              halted,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          state, state_nxt;
  logic [OP_W-1:0] op;
  logic            do_ld, do_clr, do_mac, do_out;
  logic            illegal;
  logic            loop_ok;
  logic            unused_bits;
  logic [PTR_W-1:0] wptr, cptr, sptr;

  assign op          = op_of(instr);
  assign loop_iter   = instr[ITER_HI:ITER_LO];
  assign loop_size   = instr[SIZE_HI:SIZE_LO];
  assign loop_ok     = (|loop_iter) && (|loop_size);
  assign unused_bits = ^instr[15:12];
  assign halted      = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    loop_we   = 1'b0;
    do_ld     = 1'b0;
    do_clr    = 1'b0;
    do_mac    = 1'b0;
    do_out    = 1'b0;
    illegal   = 1'b0;
    if (state == S_RUN) begin
      unique case (op)
        OP_NOP:    ;
        OP_LOOP: begin
          loop_we = loop_ok;
          illegal = !loop_ok;
        end
        OP_CLRACC: do_clr = 1'b1;
        OP_MAC:    do_mac = 1'b1;
        OP_LDSAMP: do_ld  = 1'b1;
        OP_OUT:    do_out = 1'b1;
        OP_HALT:   state_nxt = S_HALT;
        default:   illegal = 1'b1;
      endcase
`ifdef DECODE_TRAP_EN
      if (illegal) state_nxt = S_HALT;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  fir_ptr_gen #(.TAPS(TAPS), .PTR_W(PTR_W)) u_ptr (
    .clk   (clk),
    .reset (reset),
    .ld    (do_ld),
    .clr   (do_clr),
    .mac   (do_mac),
    .wptr  (wptr),
    .cptr  (cptr),
    .sptr  (sptr)
  );

  // Addresses only move with their strobe; otherwise they hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_we    <= 1'b0;
      acc_clr    <= 1'b0;
      mac_en     <= 1'b0;
      out_we     <= 1'b0;
      samp_waddr <= '0;
      samp_raddr <= '0;
      coef_addr  <= '0;
    end else begin
      samp_we <= do_ld;
      acc_clr <= do_clr;
      mac_en  <= do_mac;
      out_we  <= do_out;
      if (do_ld) samp_waddr <= wptr;
      if (do_mac) begin
        samp_raddr <= sptr;
        coef_addr  <= cptr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (illegal && !err) begin
      err      <= 1'b1;
      err_addr <= instr_addr;
    end
  end

endmodule

// File: tb/tb_fir_instr_decode.sv
// Bench for fir_instr_decode: directed program plus a cycle model.
// Honours DECODE_TRAP_EN the same way as the design build.
module tb_fir_instr_decode;
  localparam int TAPS = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr = '0;
  logic [15:0] instr_addr = '0;
  logic        loop_we;
  logic [11:0] loop_iter, loop_size;
  logic        samp_we, acc_clr, mac_en, out_we, halted, err;
  logic [3:0]  samp_waddr, samp_raddr, coef_addr;
  logic [15:0] err_addr;

  int total = 0;
  int bad = 0;

  fir_instr_decode #(.TAPS(TAPS), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_addr(instr_addr),
    .loop_we(loop_we), .loop_iter(loop_iter), .loop_size(loop_size),
    .samp_we(samp_we), .samp_waddr(samp_waddr),
    .samp_raddr(samp_raddr), .coef_addr(coef_addr),
    .acc_clr(acc_clr), .mac_en(mac_en), .out_we(out_we),
    .halted(halted), .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain integers modulo TAPS.
  int m_w = 0, m_c = 0, m_s = 0;
  int m_waddr = 0, m_raddr = 0, m_coef = 0;
  bit m_samp = 0, m_acc = 0, m_mac = 0, m_out = 0;
  bit m_halted = 0, m_err = 0;
  int m_err_addr = 0;

  always @(posedge clk or posedge reset) begin
    int op, it, sz;
    bit illegal;
    if (reset) begin
      m_w = 0; m_c = 0; m_s = 0;
      m_waddr = 0; m_raddr = 0; m_coef = 0;
      m_samp = 0; m_acc = 0; m_mac = 0; m_out = 0;
      m_halted = 0; m_err = 0; m_err_addr = 0;
    end else begin
      op = int'(instr[31:28]);
      it = int'(instr[27:16]);
      sz = int'(instr[11:0]);
      m_samp = 0; m_acc = 0; m_mac = 0; m_out = 0;
      if (!m_halted) begin
        illegal = (op >= 6 && op <= 14) || (op == 1 && (it == 0 || sz == 0));
        if (op == 4) begin
          m_samp = 1; m_waddr = m_w; m_s = m_w;
          m_w = (m_w + 1) % TAPS; m_c = 0;
        end else if (op == 2) begin
          m_acc = 1; m_c = 0; m_s = (m_w + TAPS - 1) % TAPS;
        end else if (op == 3) begin
          m_mac = 1; m_coef = m_c; m_raddr = m_s;
          m_c = (m_c + 1) % TAPS; m_s = (m_s + TAPS - 1) % TAPS;
        end else if (op == 5) begin
          m_out = 1;
        end else if (op == 15) begin
          m_halted = 1;
        end
        if (illegal) begin
          if (!m_err) begin
            m_err = 1; m_err_addr = int'(instr_addr);
          end
`ifdef DECODE_TRAP_EN
          m_halted = 1;
`endif
        end
      end
    end
  end

  // Compare process: every falling edge.
  always @(negedge clk) begin
    bit lw;
    lw = !m_halted && instr[31:28] == 4'h1 &&
         instr[27:16] != 0 && instr[11:0] != 0;
    chk("m_loop_we", loop_we, lw);
    chk("m_loop_iter", loop_iter, instr[27:16]);
    chk("m_loop_size", loop_size, instr[11:0]);
    chk("m_samp_we", samp_we, m_samp);
    chk("m_acc_clr", acc_clr, m_acc);
    chk("m_mac_en", mac_en, m_mac);
    chk("m_out_we", out_we, m_out);
    chk("m_halted", halted, m_halted);
    chk("m_err", err, m_err);
    chk("m_err_addr", err_addr, m_err_addr);
    if (m_samp) chk("m_samp_waddr", samp_waddr, m_waddr);
    if (m_mac) begin
      chk("m_samp_raddr", samp_raddr, m_raddr);
      chk("m_coef_addr", coef_addr, m_coef);
    end
  end

  task automatic step(input logic [31:0] i, input logic [15:0] a);
    instr = i;
    instr_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr = '0;
    #2;
    chk("rst_strobes", {samp_we, acc_clr, mac_en, out_we}, 0);
    chk("rst_ptrs", {samp_waddr, samp_raddr, coef_addr}, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", {err, err_addr}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int exp_r[16] = '{2,1,0,15,14,13,12,11,10,9,8,7,6,5,4,3};
    #1;
    @(posedge clk);
    #1;
    do_reset();

    // 1: NOP stream
    for (int k = 0; k < 4; k++) step(32'h0, 16'(k));
    chk("nop_strobes", {samp_we, acc_clr, mac_en, out_we}, 0);
    chk("nop_flags", {halted, err}, 0);

    // 2: LOOP setup is combinational
    instr = 32'h1003_0002;
    instr_addr = 16'd5;
    #1;
    chk("loop_we", loop_we, 1);
    chk("loop_iter", loop_iter, 3);
    chk("loop_size", loop_size, 2);
    @(posedge clk);
    #1;
    chk("loop_nostrobe", {samp_we, acc_clr, mac_en, out_we}, 0);

    // 3: 17 LDSAMP, write pointer wraps
    do_reset();
    for (int k = 0; k < 17; k++) begin
      step(32'h4000_0000, 16'(k));
      chk("ld_we", samp_we, 1);
      chk("ld_waddr", samp_waddr, k % 16);
    end

    // 4: 3 LDSAMP, CLRACC, 16 MAC
    do_reset();
    for (int k = 0; k < 3; k++) step(32'h4000_0000, 16'(k));
    step(32'h2000_0000, 16'd3);
    chk("clr_pulse", acc_clr, 1);
    for (int k = 0; k < 16; k++) begin
      step(32'h3000_0000, 16'(4 + k));
      chk("mac_en", {acc_clr, mac_en}, 1);
      chk("mac_coef", coef_addr, k);
      chk("mac_raddr", samp_raddr, exp_r[k]);
    end
    step(32'h5000_0000, 16'd20);
    chk("out_we", {mac_en, out_we}, 1);

    // 5: illegal ops, first one recorded
    do_reset();
    step(32'h0, 16'h1f);
    step(32'h7000_0000, 16'h20);
    chk("ill_err", err, 1);
    chk("ill_addr", err_addr, 16'h20);
    step(32'h8000_0000, 16'h21);
    chk("ill_keep", err_addr, 16'h20);
    step(32'h4000_0000, 16'h22);
`ifdef DECODE_TRAP_EN
    chk("trap_halt", {halted, samp_we}, 2'b10);
`else
    chk("notrap_run", {halted, samp_we}, 2'b01);
`endif
    do_reset();
    step(32'h1000_0005, 16'h9);
    chk("loop0_err", {err, err_addr}, {1'b1, 16'h9});

    // 6: HALT freezes everything; reset mid-run restores RUN
    do_reset();
    step(32'h4000_0000, 16'h0);
    step(32'hF000_0000, 16'h1);
    chk("halt", halted, 1);
    step(32'h3000_0000, 16'h2);
    chk("halt_mac", mac_en, 0);
    instr = 32'h1003_0002;
    #1;
    chk("halt_loop", loop_we, 0);
    step(32'h9000_0000, 16'h3);
    chk("halt_noerr", err, 0);
    do_reset();
    chk("rst_run", halted, 0);
    step(32'h1004_0003, 16'h0);
    step(32'h4000_0000, 16'h1);
    step(32'h4000_0000, 16'h2);
    step(32'h3000_0000, 16'h3);
    chk("pre_rst_mac", {mac_en, samp_raddr}, {1'b1, 4'd1});
    instr = 32'h3000_0000;
    do_reset();
    step(32'h0, 16'h0);
    chk("post_rst", {mac_en, samp_raddr, coef_addr}, 0);
    step(32'h4000_0000, 16'h1);
    chk("post_rst_wptr", samp_waddr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
